// File: rtl/iter_counter.sv
// -----------------------------------------------------------------------------
// iter_counter
//
// Purpose:
//   Up/down counter with a terminal-count pulse, plus an iteration-run mode.
//   A run counts 0..len_q upward on enabled steps and then pulses done.
//   Synchronous request priority per cycle is: sync_rst > load > start > en.
//
// Optional feature:
//   `define ITER_COUNTER_SAT_EN adds the input port sat. When sat=1, free-mode
//   steps saturate at the range ends instead of wrapping. tc still pulses on
//   each step that tries to leave a boundary.
//
// Parameters:
//   SIZE  count width in bits (>= 2)
//   MAX   terminal value; count range is 0..MAX (MAX <= 2**SIZE-1)
//
// Ports:
//   clk       single clock; all state updates on posedge
//   rst       asynchronous active-low reset
//   sync_rst  synchronous clear (highest synchronous priority)
//   en        count enable
//   up        free-mode direction: 1 increment, 0 decrement
//   load      synchronous load of min(load_val, MAX); aborts a run
//   load_val  load value
//   start     start a run of len_in+1 enabled steps (accepted only in IDLE)
//   len_in    run terminal index, captured as min(len_in, MAX) on start
//   sat       (ITER_COUNTER_SAT_EN only) saturate instead of wrap in IDLE
//   count     current count (registered)
//   tc        one-cycle terminal-count pulse (registered)
//   busy      high while a run is in progress
//   done      one-cycle run-complete pulse (registered)
// -----------------------------------------------------------------------------
module iter_counter #(
  parameter int SIZE = 8,
  parameter int MAX  = 2**SIZE-1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync_rst,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            start,
  input  logic [SIZE-1:0] len_in,
`ifdef ITER_COUNTER_SAT_EN
  input  logic            sat,
`endif
  output logic [SIZE-1:0] count,
  output logic            tc,
  output logic            busy,
  output logic            done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SIZE-1:0] MAX_V  = SIZE'(MAX);
  localparam logic [SIZE-1:0] ZERO_V = '0;
  localparam logic [SIZE-1:0] ONE_V  = SIZE'(1);

  state_t          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] len_q,   len_d;
  logic            tc_q,    tc_d;
  logic            done_q,  done_d;
  logic            sat_on;

`ifdef ITER_COUNTER_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments, so every always_ff
  // samples the values from before the edge regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch. tc and done default low, which makes them
  // single-cycle pulses.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    tc_d    = 1'b0;
    done_d  = 1'b0;

    if (sync_rst) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      // A load during a run aborts it without a done pulse.
      state_d = IDLE;
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (start && (state_q == IDLE)) begin
      state_d = RUN;
      count_d = '0;
      len_d   = (len_in > MAX_V) ? MAX_V : len_in;
    end else if (en) begin
      if (state_q == RUN) begin
        // A run always counts upward and ignores up. When the count reaches
        // len_q, the next enabled step ends the run and leaves the count
        // unchanged.
        if (count_q == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + ONE_V;
        end
      end else if (up) begin
        if (count_q == MAX_V) begin
          tc_d    = 1'b1;
          count_d = sat_on ? MAX_V : ZERO_V;
        end else begin
          count_d = count_q + ONE_V;
        end
      end else begin
        if (count_q == ZERO_V) begin
          tc_d    = 1'b1;
          count_d = sat_on ? ZERO_V : MAX_V;
        end else begin
          count_d = count_q - ONE_V;
        end
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);

endmodule
